// File: rtl/keycode_fifo_pio.sv
// keycode_fifo_pio
//   Avalon-MM slave that queues keycodes written by the CPU and streams them
//   to the voice logic over a valid/ready handshake. The head of the FIFO is
//   presented first-word fall-through.
//
//   Register map (address):
//     0 DATA    : write pushes writedata[DATA_WIDTH-1:0]; read returns head or 0
//     1 STATUS  : rd {count[8+:CNT_W], drained[4], overflow[2], full[1], empty[0]}
//                 wr bit2 clears overflow, bit3 flushes, bit4 clears drained
//     2 CONTROL : bit0 stream_en, bit1 ovf_irq_en, bit2 drain_irq_en
//     3         : reads 0, writes ignored
//
//   Ports:
//     clk, reset_n              clock, asynchronous active-low reset
//     address, chipselect,
//     write_n, writedata        Avalon-MM write side
//     readdata                  combinational read data, zero-extended
//     out_keycode, out_valid,
//     out_ready                 keycode stream to the voice allocator
//     irq                       level interrupt (KEYCODE_FIFO_IRQ_EN only)
//
//   Build option: define KEYCODE_FIFO_IRQ_EN to add the irq port, the drained
//   flag and the two interrupt enables. Without it those read as 0.
`timescale 1ns/1ps

module keycode_fifo_pio #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [1:0]            address,
  input  logic                  chipselect,
  input  logic                  write_n,
  input  logic [31:0]           writedata,
  output logic [31:0]           readdata,
  output logic [DATA_WIDTH-1:0] out_keycode,
  output logic                  out_valid,
  input  logic                  out_ready
`ifdef KEYCODE_FIFO_IRQ_EN
  ,
  output logic                  irq
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] ONE_CNT  = CNT_W'(1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      rd_ptr;
  logic [PTR_W-1:0]      wr_ptr;
  logic [CNT_W-1:0]      count;
  logic                  overflow;
  logic                  drained;
  logic                  stream_en;

  logic wr;
  logic data_wr;
  logic status_wr;
  logic ctrl_wr;
  logic flush;
  logic empty;
  logic full;
  logic push;
  logic pop;
  logic ovf_set;
  logic ovf_clr;
  logic unused_wdata;

  assign wr        = chipselect & ~write_n;
  assign data_wr   = wr & (address == 2'd0);
  assign status_wr = wr & (address == 2'd1);
  assign ctrl_wr   = wr & (address == 2'd2);
  assign flush     = status_wr & writedata[3];

  assign empty = (count == '0);
  assign full  = (count == FULL_CNT);

  // Full is judged on the registered count, so a pop in the same cycle does
  // not make room for a push that arrives while full.
  assign push = data_wr & ~full & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  // A push discarded by a flush is not an overflow.
  assign ovf_set = data_wr & full & ~flush;
  assign ovf_clr = status_wr & writedata[2];

  assign out_valid   = stream_en & ~empty;
  assign out_keycode = mem[rd_ptr];

  // Only a subset of writedata bits is decoded.
  assign unused_wdata = ^writedata;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      count     <= '0;
      overflow  <= 1'b0;
      stream_en <= 1'b1;
    end else begin
      if (flush) begin
        rd_ptr <= '0;
        wr_ptr <= '0;
        count  <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + PTR_W'(1);
        if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        case ({push, pop})
          2'b10:   count <= count + ONE_CNT;
          2'b01:   count <= count - ONE_CNT;
          default: count <= count;
        endcase
      end
      // Set has priority over a same-cycle clear.
      overflow <= ovf_set | (overflow & ~ovf_clr);
      if (ctrl_wr) stream_en <= writedata[0];
    end
  end

  // Storage needs no reset: entries are only observed once pushed.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= writedata[DATA_WIDTH-1:0];
  end

`ifdef KEYCODE_FIFO_IRQ_EN
  logic ovf_irq_en;
  logic drain_irq_en;
  logic drain_set;
  logic drain_clr;

  // Drained marks the last entry leaving; a simultaneous push keeps it non-empty.
  assign drain_set = pop & ~push & (count == ONE_CNT);
  assign drain_clr = status_wr & writedata[4];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      drained      <= 1'b0;
      ovf_irq_en   <= 1'b0;
      drain_irq_en <= 1'b0;
    end else begin
      drained <= drain_set | (drained & ~drain_clr);
      if (ctrl_wr) begin
        ovf_irq_en   <= writedata[1];
        drain_irq_en <= writedata[2];
      end
    end
  end

  assign irq = (ovf_irq_en & overflow) | (drain_irq_en & drained);
`else
  assign drained = 1'b0;
`endif

  always_comb begin
    readdata = '0;
    case (address)
      2'd0: begin
        if (!empty) readdata[DATA_WIDTH-1:0] = mem[rd_ptr];
      end
      2'd1: begin
        readdata[0]         = empty;
        readdata[1]         = full;
        readdata[2]         = overflow;
        readdata[4]         = drained;
        readdata[8 +: CNT_W] = count;
      end
      2'd2: begin
        readdata[0] = stream_en;
`ifdef KEYCODE_FIFO_IRQ_EN
        readdata[1] = ovf_irq_en;
        readdata[2] = drain_irq_en;
`endif
      end
      default: readdata = '0;
    endcase
  end

endmodule

// File: doc/keycode_fifo_pio.md
# keycode_fifo_pio

Avalon-MM slave that buffers keycodes written by the Nios II into a parametrised FIFO and streams them to the synth voice logic over a valid/ready interface. It replaces the single-register keycode output port, so rapid key events and chords are no longer overwritten before the voice allocator consumes them. It adds status, flush and overflow reporting, plus an optional interrupt.

## Interface
- DATA_WIDTH, 8: keycode width; 1..16.
- DEPTH, 8: FIFO entries; power of two, 2..256. Derived localparam CNT_W = log2(DEPTH)+1.
- clk  in  1  system clock.
- reset_n  in  1  asynchronous, active-low reset.
- address  in  2  register select.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; qualified by chipselect.
- writedata  in  32  write data.
- readdata  out  32  combinational read data, zero-extended.
- out_keycode  out  DATA_WIDTH  FIFO head (first-word fall-through).
- out_valid  out  1  head valid and streaming enabled.
- out_ready  in  1  consumer accepts head.
- irq  out  1  level interrupt; present only with KEYCODE_FIFO_IRQ_EN.

## Operation
- The block has one clock and one reset. reset_n is asynchronous and active-low; clk is the single clock.
- Register map:
  - 0 DATA: a write pushes writedata[DATA_WIDTH-1:0]. A read returns the head entry, or 0 when empty. Reads have no side effects.
  - 1 STATUS (read):
    - bit0 empty, bit1 full, bit2 overflow (sticky), bit4 drained (sticky).
    - bits[8+CNT_W-1:8] count.
  - 1 STATUS (write):
    - bit2=1 clears overflow; bit4=1 clears drained.
    - bit3=1 flushes: count, read pointer and write pointer go to 0.
  - 2 CONTROL (R/W): bit0 stream_en, bit1 ovf_irq_en, bit2 drain_irq_en. Other bits read 0.
  - 3: reads 0; writes are ignored.
- Write strobe: wr = chipselect & ~write_n.
- Push: a push occurs when wr, address==0, count<DEPTH, and no flush is in the same cycle.
- Pop: pop = out_valid & out_ready.
- Outputs:
  - out_valid = stream_en & (count!=0).
  - out_keycode = mem[rd_ptr] whenever the FIFO is non-empty; its value is don't-care when empty.
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. count changes by +push-pop.
- Boundary rules:
  - Push while full (count==DEPTH at the edge) is dropped and sets overflow, even if a pop happens in the same cycle. Full is judged on the registered count.
  - Push and pop in the same cycle with 0<count<DEPTH: both happen and count is unchanged.
  - Flush in the same cycle as a push or pop: flush wins. The push is discarded without setting overflow, and the pop is lost.
  - Clearing a sticky bit in the same cycle it is set: set wins.
  - stream_en=0 holds out_valid low; FIFO contents and pushes are unaffected.
  - drained is set when a pop takes count from 1 to 0. A flush does not set it.
  - Reset mid-stream: FIFO empties immediately and the asynchronous reset values below apply.
- Reset values:
  - Pointers, count, overflow and drained: 0.
  - stream_en=1; ovf_irq_en=0; drain_irq_en=0.
  - Outputs: out_valid=0, readdata follows address (STATUS reads empty=1), irq=0.

## Timing
- readdata is combinational from address and the current registers, with zero wait states.
- A DATA write at edge N makes count and the head visible after N. out_valid rises in cycle N+1 when the FIFO was empty.
- A pop at edge N presents the next entry in cycle N+1. A consumer holding out_ready=1 drains one entry per cycle.
- Status bits, count and irq are registered or derived from registers, so they update one edge after the causing event.

## Configuration
- KEYCODE_FIFO_IRQ_EN:
  - Defined: the irq port exists, with irq = (ovf_irq_en & overflow) | (drain_irq_en & drained). The level holds until software clears the sticky bit.
  - Undefined: no irq port; CONTROL bits 1 and 2 are read-only 0; STATUS bit4 reads 0 and the drained logic is removed.
  - The FIFO, overflow and flush behaviour are identical in both builds.

## Test plan
- Reset, then read addr 1: expect 0x00000001 (empty). out_valid=0, and out_valid stays 0 with out_ready=1.
- DATA_WIDTH=8, DEPTH=8, out_ready=0: write 0x3C, 0x40, 0x43, then read addr 0 -> expect 0x3C and count=3. Raise out_ready -> out_keycode is 0x3C, 0x40, 0x43 on consecutive cycles, then out_valid=0.
- Overflow: write 9 keycodes 0x10..0x18 with out_ready=0 -> STATUS shows full=1, overflow=1, count=8, and 0x18 is lost. Write 0x4 to addr 1 -> overflow=0. Concurrent push and pop while full -> push dropped and overflow sets again.
- Flush: with 5 entries queued, write 0x8 to addr 1 in the same cycle out_ready=1 -> count=0 next cycle, empty=1, overflow unchanged, drained=0.
- Stream gating: write 0 to CONTROL, push 0x30 with out_ready=1 -> out_valid stays 0. Write 1 to CONTROL -> out_valid=1 next cycle and 0x30 is popped.
- With KEYCODE_FIFO_IRQ_EN: write 0x5 to CONTROL (enables stream and drain irq), push 0x50, pop it -> irq=1 one cycle after the pop. Write 0x10 to addr 1 -> irq=0.
